// File: rtl/stopwatch_pkg.sv
// Shared types and time arithmetic for the multi-lap stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        STOP_LIVE   = 2'd0,
        RUN_LIVE    = 2'd1,
        RUN_FROZEN  = 2'd2,
        STOP_FROZEN = 2'd3
    } sw_state_e;

    localparam logic [6:0] MS10_MAX = 7'd99;
    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam int         TIME_W   = 19;

    typedef struct packed {
        logic [5:0] min;
        logic [5:0] sec;
        logic [6:0] ms_10;
    } sw_time_t;

    function automatic sw_time_t time_inc(input sw_time_t t, input logic [5:0] min_max);
        sw_time_t r;
        r = t;
        if (t.ms_10 < MS10_MAX) begin
            r.ms_10 = t.ms_10 + 7'd1;
        end else begin
            r.ms_10 = '0;
            if (t.sec < SEC_MAX) begin
                r.sec = t.sec + 6'd1;
            end else begin
                r.sec = '0;
                if (t.min < min_max) r.min = t.min + 6'd1;
                else                 r.min = '0;
            end
        end
        return r;
    endfunction

    // a - b with per-digit borrow; a negative minute difference wraps by (min_max+1).
    function automatic sw_time_t time_sub(input sw_time_t a, input sw_time_t b,
                                          input logic [5:0] min_max);
        sw_time_t   r;
        logic       b_ms;
        logic       b_sec;
        logic       b_min;
        logic [7:0] ms;
        logic [6:0] sec;
        logic [6:0] mn;
        b_ms  = (a.ms_10 < b.ms_10);
        ms    = {1'b0, a.ms_10} - {1'b0, b.ms_10} + (b_ms ? 8'd100 : 8'd0);
        b_sec = ({1'b0, a.sec} < ({1'b0, b.sec} + {6'd0, b_ms}));
        sec   = {1'b0, a.sec} - {1'b0, b.sec} - {6'd0, b_ms} + (b_sec ? 7'd60 : 7'd0);
        b_min = ({1'b0, a.min} < ({1'b0, b.min} + {6'd0, b_sec}));
        mn    = {1'b0, a.min} - {1'b0, b.min} - {6'd0, b_sec}
              + (b_min ? ({1'b0, min_max} + 7'd1) : 7'd0);
        r.ms_10 = ms[6:0];
        r.sec   = sec[5:0];
        r.min   = mn[5:0];
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_lap_ctrl_lap_fifo.sv
// Circular lap-time buffer: overwrite-oldest on full, registered pop port with valid strobe.
module lap_fifo
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  sw_time_t                 i_data,
    input  logic                     i_pop,
    output sw_time_t                 o_data,
    output logic                     o_vld,
    output logic [$clog2(DEPTH):0]   o_cnt,
    output logic                     o_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    sw_time_t      r_mem [DEPTH];
    sw_time_t      r_data;
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          r_ovf;
    logic          r_vld;

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full = (r_cnt == FULL_CNT);
    assign w_push = i_push & ~i_clr;
    assign w_pop  = i_pop & (r_cnt != '0) & ~i_clr;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    // A simultaneous pop frees the oldest slot, so push+pop never counts as an overwrite.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_vld  <= 1'b0;
            r_data <= '0;
        end else begin
            r_vld <= w_pop;
            if (i_clr) begin
                r_wr  <= '0;
                r_rd  <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else begin
                if (w_pop) r_data <= r_mem[r_rd];
                if (w_push) r_wr <= r_wr + 1'b1;
                if (w_pop || (w_push && w_full)) r_rd <= r_rd + 1'b1;
                if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
                if (w_push && !w_pop && !w_full)  r_cnt <= r_cnt + 1'b1;
                else if (w_pop && !w_push)        r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_data = r_data;
    assign o_vld  = r_vld;
    assign o_cnt  = r_cnt;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch with prescaler, min:sec.10ms counter, freeze-on-lap display and lap buffer.
// Define STOPWATCH_SPLIT_EN to store split times (since previous lap/clear) instead of absolute.
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 500000,
    parameter int LAP_DEPTH = 8,
    parameter int MIN_MAX   = 59
) (
    input  logic                         clk_core,
    input  logic                         rst,
    input  logic                         start_stop,
    input  logic                         lap,
    input  logic                         clear,
    input  logic                         lap_rd,
    output logic [5:0]                   min_o,
    output logic [5:0]                   sec_o,
    output logic [6:0]                   ms_10_o,
    output logic                         running,
    output logic                         frozen,
    output logic [5:0]                   lap_min,
    output logic [5:0]                   lap_sec,
    output logic [6:0]                   lap_ms_10,
    output logic                         lap_vld,
    output logic [$clog2(LAP_DEPTH):0]   lap_cnt,
    output logic                         lap_ovf
);

    localparam int          PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [5:0]  MIN_MAX_L  = 6'(MIN_MAX);

    sw_state_e     r_state;
    sw_state_e     w_next;
    logic [PW-1:0] r_presc;
    sw_time_t      r_time;
    sw_time_t      r_disp;
    sw_time_t      w_push_val;
    sw_time_t      w_lap_data;

    logic w_conflict;
    logic w_ss;
    logic w_lap;
    logic w_clr;
    logic w_push;
    logic w_do_clear;
    logic w_run;
    logic w_live;
    logic w_tick;

    // Two or more commands in one cycle are ambiguous, so the whole command is dropped.
    assign w_conflict = (start_stop & lap) | (start_stop & clear) | (lap & clear);
    assign w_ss       = start_stop & ~w_conflict;
    assign w_lap      = lap & ~w_conflict;
    assign w_clr      = clear & ~w_conflict;

    assign w_run  = (r_state == RUN_LIVE) || (r_state == RUN_FROZEN);
    assign w_live = (r_state == RUN_LIVE) || (r_state == STOP_LIVE);
    assign w_tick = w_run && (r_presc == PRESC_LAST);

    always_comb begin
        w_next     = r_state;
        w_push     = 1'b0;
        w_do_clear = 1'b0;
        case (r_state)
            STOP_LIVE: begin
                if (w_ss)       w_next = RUN_LIVE;
                else if (w_clr) w_do_clear = 1'b1;
            end
            RUN_LIVE: begin
                if (w_ss) begin
                    w_next = STOP_LIVE;
                end else if (w_lap) begin
                    w_next = RUN_FROZEN;
                    w_push = 1'b1;
                end
            end
            RUN_FROZEN: begin
                if (w_ss) begin
                    w_next = STOP_FROZEN;
                end else if (w_lap) begin
                    w_next = RUN_LIVE;
                    w_push = 1'b1;
                end
            end
            STOP_FROZEN: begin
                if (w_ss) begin
                    w_next = RUN_FROZEN;
                end else if (w_lap) begin
                    w_next = STOP_LIVE;
                end else if (w_clr) begin
                    w_next     = STOP_LIVE;
                    w_do_clear = 1'b1;
                end
            end
            default: w_next = STOP_LIVE;
        endcase
    end

    always_ff @(posedge clk_core or negedge rst) begin
        if (!rst) r_state <= STOP_LIVE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk_core or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_time  <= '0;
        end else if (w_do_clear) begin
            r_presc <= '0;
            r_time  <= '0;
        end else if (w_run) begin
            if (w_tick) begin
                r_presc <= '0;
                r_time  <= time_inc(r_time, MIN_MAX_L);
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // The freeze edge is still a LIVE cycle, so the held value equals the pushed time.
    always_ff @(posedge clk_core or negedge rst) begin
        if (!rst)        r_disp <= '0;
        else if (w_live) r_disp <= r_time;
    end

`ifdef STOPWATCH_SPLIT_EN
    sw_time_t r_last;

    always_ff @(posedge clk_core or negedge rst) begin
        if (!rst)            r_last <= '0;
        else if (w_do_clear) r_last <= '0;
        else if (w_push)     r_last <= r_time;
    end

    assign w_push_val = time_sub(r_time, r_last, MIN_MAX_L);
`else
    assign w_push_val = r_time;
`endif

    lap_fifo #(
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk    (clk_core),
        .rst_n  (rst),
        .i_clr  (w_do_clear),
        .i_push (w_push),
        .i_data (w_push_val),
        .i_pop  (lap_rd),
        .o_data (w_lap_data),
        .o_vld  (lap_vld),
        .o_cnt  (lap_cnt),
        .o_ovf  (lap_ovf)
    );

    assign min_o     = r_disp.min;
    assign sec_o     = r_disp.sec;
    assign ms_10_o   = r_disp.ms_10;
    assign running   = w_run;
    assign frozen    = (r_state == RUN_FROZEN) || (r_state == STOP_FROZEN);
    assign lap_min   = w_lap_data.min;
    assign lap_sec   = w_lap_data.sec;
    assign lap_ms_10 = w_lap_data.ms_10;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed self-checking bench for stopwatch_lap_ctrl (TICK_DIV=4, LAP_DEPTH=4, MIN_MAX=1).
// Expected lap entries follow STOPWATCH_SPLIT_EN when it is defined for the build.
module tb_stopwatch_lap_ctrl;

    localparam int TD = 4;
    localparam int LD = 4;
    localparam int MM = 1;

`ifdef STOPWATCH_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic       clk_core = 1'b0;
    logic       rst = 1'b1;
    logic       start_stop = 1'b0;
    logic       lap = 1'b0;
    logic       clear = 1'b0;
    logic       lap_rd = 1'b0;
    logic [5:0] min_o;
    logic [5:0] sec_o;
    logic [6:0] ms_10_o;
    logic       running;
    logic       frozen;
    logic [5:0] lap_min;
    logic [5:0] lap_sec;
    logic [6:0] lap_ms_10;
    logic       lap_vld;
    logic [2:0] lap_cnt;
    logic       lap_ovf;

    logic [18:0] disp;
    logic [18:0] lapv;
    assign disp = {min_o, sec_o, ms_10_o};
    assign lapv = {lap_min, lap_sec, lap_ms_10};

    int tests_run    = 0;
    int tests_failed = 0;

    stopwatch_lap_ctrl #(
        .TICK_DIV  (TD),
        .LAP_DEPTH (LD),
        .MIN_MAX   (MM)
    ) dut (
        .clk_core   (clk_core),
        .rst        (rst),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .lap_rd     (lap_rd),
        .min_o      (min_o),
        .sec_o      (sec_o),
        .ms_10_o    (ms_10_o),
        .running    (running),
        .frozen     (frozen),
        .lap_min    (lap_min),
        .lap_sec    (lap_sec),
        .lap_ms_10  (lap_ms_10),
        .lap_vld    (lap_vld),
        .lap_cnt    (lap_cnt),
        .lap_ovf    (lap_ovf)
    );

    always #5 clk_core = ~clk_core;

    function automatic logic [18:0] tv(input int m, input int s, input int c);
        return {6'(m), 6'(s), 7'(c)};
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_core);
    endtask

    // Drives one-cycle command pulses; returns on the negedge after the sampling posedge.
    task automatic pulse(input logic s, input logic l, input logic c, input logic r);
        @(negedge clk_core);
        start_stop = s; lap = l; clear = c; lap_rd = r;
        @(negedge clk_core);
        start_stop = 1'b0; lap = 1'b0; clear = 1'b0; lap_rd = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_core);
        rst = 1'b0;
        @(negedge clk_core);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #20;
        tests_run++;
        if (disp !== tv(0, 0, 0)) begin tests_failed++; $display("[TB] FAIL reset_display: got %h required %h", disp, tv(0, 0, 0)); end
        tests_run++;
        if ({running, frozen, lap_vld, lap_ovf} !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_flags: got %b required 0000", {running, frozen, lap_vld, lap_ovf}); end
        tests_run++;
        if (lap_cnt !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_lap_cnt: got %0d required 0", lap_cnt); end
        tests_run++;
        if (lapv !== 19'd0) begin tests_failed++; $display("[TB] FAIL reset_lap_data: got %h required 0", lapv); end
        @(negedge clk_core);
        rst = 1'b1;
    endtask

    task automatic test_count_and_wrap();
        pulse(1, 0, 0, 0);
        wait_cyc(400);
        tests_run++;
        if (disp !== tv(0, 0, 99)) begin tests_failed++; $display("[TB] FAIL count_99: got %h required %h", disp, tv(0, 0, 99)); end
        tests_run++;
        if (running !== 1'b1) begin tests_failed++; $display("[TB] FAIL count_running: got %b required 1", running); end
        wait_cyc(4);
        tests_run++;
        if (disp !== tv(0, 1, 0)) begin tests_failed++; $display("[TB] FAIL count_1s: got %h required %h", disp, tv(0, 1, 0)); end
        wait_cyc(23596);
        tests_run++;
        if (disp !== tv(0, 59, 99)) begin tests_failed++; $display("[TB] FAIL count_5999: got %h required %h", disp, tv(0, 59, 99)); end
        wait_cyc(1);
        tests_run++;
        if (disp !== tv(1, 0, 0)) begin tests_failed++; $display("[TB] FAIL count_min_carry: got %h required %h", disp, tv(1, 0, 0)); end
        wait_cyc(23999);
        tests_run++;
        if (disp !== tv(1, 59, 99)) begin tests_failed++; $display("[TB] FAIL count_max: got %h required %h", disp, tv(1, 59, 99)); end
        wait_cyc(1);
        tests_run++;
        if (disp !== tv(0, 0, 0)) begin tests_failed++; $display("[TB] FAIL count_wrap: got %h required %h", disp, tv(0, 0, 0)); end
        tests_run++;
        if (lap_ovf !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrap_ovf: got %b required 0", lap_ovf); end
        wait_cyc(40);
        pulse(1, 0, 0, 0);
        wait_cyc(20);
        tests_run++;
        if (disp !== tv(0, 0, 10)) begin tests_failed++; $display("[TB] FAIL stop_hold: got %h required %h", disp, tv(0, 0, 10)); end
        tests_run++;
        if (running !== 1'b0) begin tests_failed++; $display("[TB] FAIL stop_running: got %b required 0", running); end
        pulse(1, 0, 0, 0);
        wait_cyc(2);
        tests_run++;
        if (disp !== tv(0, 0, 11)) begin tests_failed++; $display("[TB] FAIL presc_held: got %h required %h", disp, tv(0, 0, 11)); end
    endtask

    task automatic test_lap_freeze();
        do_reset();
        pulse(1, 0, 0, 0);
        wait_cyc(41);
        pulse(0, 1, 0, 0);
        tests_run++;
        if (frozen !== 1'b1) begin tests_failed++; $display("[TB] FAIL freeze_flag: got %b required 1", frozen); end
        tests_run++;
        if (disp !== tv(0, 0, 10)) begin tests_failed++; $display("[TB] FAIL freeze_latch: got %h required %h", disp, tv(0, 0, 10)); end
        wait_cyc(57);
        tests_run++;
        if (disp !== tv(0, 0, 10)) begin tests_failed++; $display("[TB] FAIL freeze_hold: got %h required %h", disp, tv(0, 0, 10)); end
        pulse(0, 1, 0, 0);
        tests_run++;
        if (frozen !== 1'b0) begin tests_failed++; $display("[TB] FAIL unfreeze_flag: got %b required 0", frozen); end
        tests_run++;
        if (lap_cnt !== 3'd2) begin tests_failed++; $display("[TB] FAIL lap_cnt_2: got %0d required 2", lap_cnt); end
        wait_cyc(1);
        tests_run++;
        if (disp !== tv(0, 0, 25)) begin tests_failed++; $display("[TB] FAIL unfreeze_live: got %h required %h", disp, tv(0, 0, 25)); end
        pulse(0, 0, 0, 1);
        tests_run++;
        if ({lap_vld, lapv} !== {1'b1, tv(0, 0, 10)}) begin tests_failed++; $display("[TB] FAIL pop1: got vld %b data %h required vld 1 data %h", lap_vld, lapv, tv(0, 0, 10)); end
        wait_cyc(1);
        tests_run++;
        if (lap_vld !== 1'b0) begin tests_failed++; $display("[TB] FAIL vld_one_cycle: got %b required 0", lap_vld); end
        pulse(0, 0, 0, 1);
        tests_run++;
        if ({lap_vld, lapv} !== {1'b1, (SPLIT ? tv(0, 0, 15) : tv(0, 0, 25))}) begin tests_failed++; $display("[TB] FAIL pop2: got vld %b data %h required vld 1 data %h", lap_vld, lapv, (SPLIT ? tv(0, 0, 15) : tv(0, 0, 25))); end
        pulse(0, 0, 0, 1);
        tests_run++;
        if ({lap_vld, lap_cnt} !== {1'b0, 3'd0}) begin tests_failed++; $display("[TB] FAIL pop_empty: got vld %b cnt %0d required vld 0 cnt 0", lap_vld, lap_cnt); end
        tests_run++;
        if (lapv !== (SPLIT ? tv(0, 0, 15) : tv(0, 0, 25))) begin tests_failed++; $display("[TB] FAIL lap_hold: got %h required %h", lapv, (SPLIT ? tv(0, 0, 15) : tv(0, 0, 25))); end
    endtask

    task automatic test_overflow();
        int w [5];
        w = '{7, 11, 3, 15, 5};
        do_reset();
        pulse(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            wait_cyc(w[i]);
            pulse(0, 1, 0, 0);
        end
        tests_run++;
        if ({lap_cnt, lap_ovf} !== {3'd4, 1'b1}) begin tests_failed++; $display("[TB] FAIL ovf_state: got cnt %0d ovf %b required cnt 4 ovf 1", lap_cnt, lap_ovf); end
        pulse(0, 0, 0, 1);
        tests_run++;
        if ({lap_vld, lapv} !== {1'b1, (SPLIT ? tv(0, 0, 3) : tv(0, 0, 5))}) begin tests_failed++; $display("[TB] FAIL ovf_oldest: got vld %b data %h required vld 1 data %h", lap_vld, lapv, (SPLIT ? tv(0, 0, 3) : tv(0, 0, 5))); end
        tests_run++;
        if (lap_cnt !== 3'd3) begin tests_failed++; $display("[TB] FAIL ovf_pop_cnt: got %0d required 3", lap_cnt); end
    endtask

    task automatic test_back_to_back();
        int          w [4];
        logic [18:0] exp_abs [4];
        logic [18:0] exp_spl [4];
        w       = '{3, 6, 3, 9};
        exp_abs = '{tv(0, 0, 3), tv(0, 0, 4), tv(0, 0, 7), tv(0, 0, 8)};
        exp_spl = '{tv(0, 0, 2), tv(0, 0, 1), tv(0, 0, 3), tv(0, 0, 1)};
        do_reset();
        pulse(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            wait_cyc(w[i]);
            pulse(0, 1, 0, 0);
        end
        tests_run++;
        if ({lap_cnt, lap_ovf} !== {3'd4, 1'b0}) begin tests_failed++; $display("[TB] FAIL full_state: got cnt %0d ovf %b required cnt 4 ovf 0", lap_cnt, lap_ovf); end
        wait_cyc(3);
        pulse(0, 1, 0, 1);
        tests_run++;
        if ({lap_vld, lapv} !== {1'b1, tv(0, 0, 1)}) begin tests_failed++; $display("[TB] FAIL pushpop_data: got vld %b data %h required vld 1 data %h", lap_vld, lapv, tv(0, 0, 1)); end
        tests_run++;
        if ({lap_cnt, lap_ovf} !== {3'd4, 1'b0}) begin tests_failed++; $display("[TB] FAIL pushpop_state: got cnt %0d ovf %b required cnt 4 ovf 0", lap_cnt, lap_ovf); end
        for (int i = 0; i < 4; i++) begin
            pulse(0, 0, 0, 1);
            tests_run++;
            if (lapv !== (SPLIT ? exp_spl[i] : exp_abs[i])) begin tests_failed++; $display("[TB] FAIL drain_%0d: got %h required %h", i, lapv, (SPLIT ? exp_spl[i] : exp_abs[i])); end
        end
        tests_run++;
        if (lap_cnt !== 3'd0) begin tests_failed++; $display("[TB] FAIL drain_cnt: got %0d required 0", lap_cnt); end
    endtask

    task automatic test_cmd_conflict();
        do_reset();
        pulse(1, 0, 0, 0);
        pulse(1, 1, 0, 0);
        tests_run++;
        if ({running, frozen, lap_cnt} !== {1'b1, 1'b0, 3'd0}) begin tests_failed++; $display("[TB] FAIL conflict_ignored: got run %b frz %b cnt %0d required run 1 frz 0 cnt 0", running, frozen, lap_cnt); end
        wait_cyc(20);
        pulse(0, 0, 1, 0);
        wait_cyc(2);
        tests_run++;
        if ({running, disp} !== {1'b1, tv(0, 0, 6)}) begin tests_failed++; $display("[TB] FAIL clear_running: got run %b disp %h required run 1 disp %h", running, disp, tv(0, 0, 6)); end
        pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        tests_run++;
        if ({running, frozen, lap_cnt, disp} !== {1'b0, 1'b1, 3'd1, tv(0, 0, 6)}) begin tests_failed++; $display("[TB] FAIL stop_frozen: got run %b frz %b cnt %0d disp %h required run 0 frz 1 cnt 1 disp %h", running, frozen, lap_cnt, disp, tv(0, 0, 6)); end
        pulse(0, 0, 1, 0);
        wait_cyc(2);
        tests_run++;
        if ({running, frozen, lap_cnt, disp} !== {1'b0, 1'b0, 3'd0, tv(0, 0, 0)}) begin tests_failed++; $display("[TB] FAIL clear_frozen: got run %b frz %b cnt %0d disp %h required run 0 frz 0 cnt 0 disp 0", running, frozen, lap_cnt, disp); end
        pulse(0, 1, 0, 0);
        tests_run++;
        if ({frozen, lap_cnt} !== {1'b0, 3'd0}) begin tests_failed++; $display("[TB] FAIL lap_stop_live: got frz %b cnt %0d required frz 0 cnt 0", frozen, lap_cnt); end
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        tests_run++;
        if ({running, frozen, lap_cnt} !== {1'b0, 1'b0, 3'd1}) begin tests_failed++; $display("[TB] FAIL lap_stop_frozen: got run %b frz %b cnt %0d required run 0 frz 0 cnt 1", running, frozen, lap_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        pulse(1, 0, 0, 0);
        wait_cyc(20);
        pulse(0, 1, 0, 0);
        pulse(0, 0, 0, 1);
        wait_cyc(1);
        tests_run++;
        if ({frozen, disp, lapv} !== {1'b1, tv(0, 0, 5), tv(0, 0, 5)}) begin tests_failed++; $display("[TB] FAIL pre_reset: got frz %b disp %h lap %h required frz 1 disp %h lap %h", frozen, disp, lapv, tv(0, 0, 5), tv(0, 0, 5)); end
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if ({running, frozen, lap_vld, lap_ovf, lap_cnt} !== 7'd0) begin tests_failed++; $display("[TB] FAIL async_flags: got run %b frz %b vld %b ovf %b cnt %0d required all 0", running, frozen, lap_vld, lap_ovf, lap_cnt); end
        tests_run++;
        if ({disp, lapv} !== 38'd0) begin tests_failed++; $display("[TB] FAIL async_data: got disp %h lap %h required 0", disp, lapv); end
        @(negedge clk_core);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_count_and_wrap();
        test_lap_freeze();
        test_overflow();
        test_back_to_back();
        test_cmd_conflict();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
